// File: rtl/fat_sector_chain_reader_pkg.sv
// fat_sector_chain_reader_pkg: FSM states, entry classes, status codes and FAT thresholds
package fat_sector_chain_reader_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EVAL, S_DONE} state_t;
  typedef enum logic [2:0] {CL_LINK, CL_FREE, CL_EOC, CL_BAD, CL_RSVD} ent_class_t;
  localparam logic [2:0] ST_OUT = 3'd0, ST_EOC = 3'd1, ST_FREE = 3'd2, ST_BAD = 3'd3,
                         ST_RSVD = 3'd4, ST_MISS = 3'd5, ST_LIMIT = 3'd6;
  localparam logic [27:0] EOC_MIN = 28'hFFFFFF8, BAD_VAL = 28'hFFFFFF7, RSVD_MIN = 28'hFFFFFF0;
  function automatic logic [2:0] class_status(input ent_class_t c);
    return c == CL_EOC ? ST_EOC : c == CL_FREE ? ST_FREE : c == CL_BAD ? ST_BAD :
           c == CL_RSVD ? ST_RSVD : ST_OUT;
  endfunction
endpackage

// File: rtl/fat_sector_chain_reader_entry_decode.sv
// fat_entry_decode: un-swaps the nibbles of each byte of a raw FAT word and classifies the 28-bit entry
module fat_entry_decode
  import fat_sector_chain_reader_pkg::*;
(
  input  logic [31:0] raw,
  output logic [27:0] value,
  output ent_class_t  cls
);
  logic unused_hi;
  assign unused_hi = ^raw[27:24];
  assign value = {raw[31:28], raw[19:16], raw[23:20], raw[11:8], raw[15:12], raw[3:0], raw[7:4]};
  always_comb begin
    cls = value == 28'd0 ? CL_FREE :
          value >= EOC_MIN ? CL_EOC :
          value == BAD_VAL ? CL_BAD :
          (value == 28'd1 || value >= RSVD_MIN) ? CL_RSVD : CL_LINK;
  end
endmodule

// File: rtl/fat_sector_chain_reader.sv
// fat_sector_chain_reader: follows a FAT cluster chain inside one loaded FAT sector buffer
// optional hop limit enabled by defining FAT_CHAIN_HOP_LIMIT_EN
module fat_sector_chain_reader
  import fat_sector_chain_reader_pkg::*;
#(
  parameter int unsigned HOP_LIMIT = 128
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] START_CLUST,
  input  logic [31:0] SECTOR_BASE,
  input  logic        SECTOR_VALID,
  output logic        RENA_SR,
  output logic [7:0]  RADDR_SR,
  input  logic [31:0] INPUT_SR,
  output logic        BUSY,
  output logic        DONE,
  output logic [2:0]  STATUS,
  output logic [31:0] LAST_CLUST,
  output logic [31:0] NEXT_CLUST,
  output logic [7:0]  HOPS
);
  state_t      state;
  logic [31:0] cur;
  logic [27:0] val;
  ent_class_t  cls;
  logic [31:0] nxt;
  logic        in_sec, miss, lim;
  logic [7:0]  hops_n;
  fat_entry_decode u_dec (.raw(INPUT_SR), .value(val), .cls(cls));
  assign nxt    = {4'd0, val};
  assign in_sec = nxt[31:7] == SECTOR_BASE[31:7];
  assign miss   = !SECTOR_VALID || START_CLUST[31:7] != SECTOR_BASE[31:7] || START_CLUST < 32'd2;
  assign hops_n = HOPS == 8'hFF ? HOPS : HOPS + 8'd1;
`ifdef FAT_CHAIN_HOP_LIMIT_EN
  logic unused_base;
  assign unused_base = ^SECTOR_BASE[6:0];
  assign lim = 32'(hops_n) >= HOP_LIMIT;
`else
  logic unused_base;
  assign unused_base = ^{SECTOR_BASE[6:0], HOP_LIMIT};
  assign lim = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      cur        <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      RENA_SR    <= 1'b0;
      RADDR_SR   <= '0;
      HOPS       <= '0;
      LAST_CLUST <= '0;
      NEXT_CLUST <= '0;
      STATUS     <= ST_OUT;
    end else begin
      DONE    <= 1'b0;
      RENA_SR <= 1'b0;
      case (state)
        S_IDLE: if (START) begin
          cur  <= START_CLUST;
          HOPS <= '0;
          if (miss) begin
            state  <= S_DONE;
            DONE   <= 1'b1;
            STATUS <= START_CLUST < 32'd2 ? ST_RSVD : ST_MISS;
          end else begin
            state    <= S_ISSUE;
            BUSY     <= 1'b1;
            RENA_SR  <= 1'b1;
            RADDR_SR <= {1'b0, START_CLUST[6:0]};
          end
        end
        S_ISSUE: state <= S_EVAL;
        S_EVAL: begin
          HOPS       <= hops_n;
          LAST_CLUST <= cur;
          NEXT_CLUST <= nxt;
          if (cls == CL_LINK && in_sec && !lim) begin
            cur      <= nxt;
            state    <= S_ISSUE;
            RENA_SR  <= 1'b1;
            RADDR_SR <= {1'b0, nxt[6:0]};
          end else begin
            state  <= S_DONE;
            DONE   <= 1'b1;
            BUSY   <= 1'b0;
            STATUS <= cls != CL_LINK ? class_status(cls) : in_sec ? ST_LIMIT : ST_OUT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fat_sector_chain_reader.sv
// tb_fat_sector_chain_reader: directed chains against a chain-walking model of the FAT reader
module tb_fat_sector_chain_reader;
  logic        CLK = 1'b0, RST = 1'b1, START = 1'b0, SECTOR_VALID = 1'b1;
  logic [31:0] START_CLUST = '0, SECTOR_BASE = 32'h80, INPUT_SR = '0;
  logic        RENA_SR, BUSY, DONE;
  logic [7:0]  RADDR_SR, HOPS;
  logic [2:0]  STATUS;
  logic [31:0] LAST_CLUST, NEXT_CLUST;
  localparam int HL = 4;
  fat_sector_chain_reader #(.HOP_LIMIT(HL)) dut (
    .CLK(CLK), .RST(RST), .START(START), .START_CLUST(START_CLUST), .SECTOR_BASE(SECTOR_BASE),
    .SECTOR_VALID(SECTOR_VALID), .RENA_SR(RENA_SR), .RADDR_SR(RADDR_SR), .INPUT_SR(INPUT_SR),
    .BUSY(BUSY), .DONE(DONE), .STATUS(STATUS), .LAST_CLUST(LAST_CLUST), .NEXT_CLUST(NEXT_CLUST),
    .HOPS(HOPS)
  );
  always #5 CLK = ~CLK;
  logic [31:0] lmem [0:127];
  logic [7:0]  aq [$];
  int n_chk = 0, n_fail = 0, cyc = 0, start_cyc = 0, e_hops = 0, e_lat = 0;
  logic [2:0]  e_st;
  logic [31:0] e_last, e_next;
  bit active = 0, done_seen = 0, free_run = 0;
  function automatic logic [31:0] swz(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {x[8*i +: 4], x[8*i+4 +: 4]};
    return r;
  endfunction
  always @(posedge CLK) if (RENA_SR) INPUT_SR <= swz(lmem[RADDR_SR[6:0]]);
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic predict(input logic [31:0] sc);
    logic [31:0] c, e;
    aq.delete();
    e_hops = 0;
    e_last = 0;
    e_next = 0;
    e_st = 3'd0;
    if (sc < 2) e_st = 3'd4;
    else if (!SECTOR_VALID || sc[31:7] != SECTOR_BASE[31:7]) e_st = 3'd5;
    else begin
      c = sc;
      for (int k = 0; k < 300; k++) begin
        aq.push_back({1'b0, c[6:0]});
        e = lmem[c[6:0]] & 32'h0FFFFFFF;
        e_hops++;
        e_last = c;
        e_next = e;
        if (e == 0) e_st = 3'd2;
        else if (e >= 32'h0FFFFFF8) e_st = 3'd1;
        else if (e == 32'h0FFFFFF7) e_st = 3'd3;
        else if (e == 1 || e >= 32'h0FFFFFF0) e_st = 3'd4;
        else if (e[31:7] != SECTOR_BASE[31:7]) e_st = 3'd0;
        else begin
`ifdef FAT_CHAIN_HOP_LIMIT_EN
          if (e_hops == HL) begin
            e_st = 3'd6;
            break;
          end
`endif
          c = e;
          continue;
        end
        break;
      end
    end
    e_lat = 1 + 2 * e_hops;
  endtask
  always @(negedge CLK) begin
    cyc++;
    if (!RST) begin
      if (!free_run) begin
        if (aq.size() == 0) chk("rena_idle", {31'd0, RENA_SR}, 0);
        else if (RENA_SR) chk("raddr", {24'd0, RADDR_SR}, {24'd0, aq.pop_front()});
      end
      if (!active) chk("done_idle", {31'd0, DONE}, 0);
      else if (!DONE && cyc > start_cyc) chk("busy", {31'd0, BUSY}, e_hops > 0);
      else if (DONE) begin
        chk("status", {29'd0, STATUS}, {29'd0, e_st});
        chk("hops", {24'd0, HOPS}, e_hops);
        chk("latency", cyc - start_cyc, e_lat);
        chk("busy_at_done", {31'd0, BUSY}, 0);
        chk("reads_left", aq.size(), 0);
        if (e_hops > 0) begin
          chk("last_clust", LAST_CLUST, e_last);
          chk("next_clust", NEXT_CLUST, e_next);
        end
        active = 0;
        done_seen = 1;
      end
    end
  end
  task automatic launch(input logic [31:0] sc, input bit now);
    predict(sc);
    if (!now) @(posedge CLK);
    #1;
    START = 1;
    START_CLUST = sc;
    RST = 0;
    done_seen = 0;
    active = 1;
    start_cyc = cyc + 1;
    @(posedge CLK);
    #1 START = 0;
  endtask
  task automatic run(input logic [31:0] sc, input bit poke);
    launch(sc, 0);
    if (poke) begin
      @(posedge CLK);
      #1 START = 1;
      START_CLUST = 32'h200;
      @(posedge CLK);
      #1 START = 0;
    end
    for (int i = 0; i < 1000 && !done_seen; i++) @(posedge CLK);
    if (!done_seen) begin
      chk("done_timeout", 0, 1);
      active = 0;
      aq.delete();
    end
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_busy"}, {31'd0, BUSY}, 0);
    chk({nm, "_done"}, {31'd0, DONE}, 0);
    chk({nm, "_rena"}, {31'd0, RENA_SR}, 0);
    chk({nm, "_raddr"}, {24'd0, RADDR_SR}, 0);
    chk({nm, "_hops"}, {24'd0, HOPS}, 0);
    chk({nm, "_last"}, LAST_CLUST, 0);
    chk({nm, "_next"}, NEXT_CLUST, 0);
    chk({nm, "_status"}, {29'd0, STATUS}, 0);
  endtask
  task automatic self_loop_start();
    free_run = 1;
    @(posedge CLK);
    #1 START = 1;
    START_CLUST = 32'h81;
    @(posedge CLK);
    #1 START = 0;
  endtask
  initial begin
    for (int i = 0; i < 128; i++) lmem[i] = 32'h0FFFFFFF;
    lmem[1] = 32'h81; lmem[2] = 32'h83; lmem[3] = 32'h84; lmem[4] = 32'h0FFFFFF8;
    lmem[5] = 32'h0FFFFFFF; lmem[6] = 32'h0; lmem[7] = 32'h0FFFFFF7; lmem[8] = 32'h1;
    lmem[9] = 32'h0FFFFFF3; lmem[10] = 32'hF0000085; lmem[11] = 32'h100; lmem[12] = 32'hFF;
    lmem[16] = 32'h105; lmem[127] = 32'h0FFFFFF9;
    repeat (3) @(posedge CLK);
    #1 chk_reset("rst");
    RST = 0;
    run(32'h85, 0);
    chk("eoc_status_lit", {29'd0, STATUS}, 1);
    chk("eoc_raddr_lit", {24'd0, RADDR_SR}, 5);
    chk("eoc_hops_lit", {24'd0, HOPS}, 1);
    SECTOR_BASE = 32'hDA;
    run(32'h82, 0);
    chk("chain_hops_lit", {24'd0, HOPS}, 3);
    chk("chain_last_lit", LAST_CLUST, 32'h84);
    SECTOR_BASE = 32'h80;
    run(32'h90, 0);
    chk("out_status_lit", {29'd0, STATUS}, 0);
    chk("out_next_lit", NEXT_CLUST, 32'h105);
    run(32'h200, 0);
    chk("miss_status_lit", {29'd0, STATUS}, 5);
    SECTOR_VALID = 0;
    run(32'h85, 0);
    SECTOR_VALID = 1;
    run(32'h1, 0);
    run(32'h86, 0);
    chk("free_status_lit", {29'd0, STATUS}, 2);
    run(32'h87, 0);
    chk("bad_status_lit", {29'd0, STATUS}, 3);
    run(32'h88, 0);
    run(32'h89, 0);
    run(32'h8A, 0);
    run(32'h8B, 0);
    run(32'h8C, 0);
    run(32'h82, 1);
    chk("poke_status_lit", {29'd0, STATUS}, 1);
`ifdef FAT_CHAIN_HOP_LIMIT_EN
    run(32'h81, 0);
    chk("limit_status_lit", {29'd0, STATUS}, 6);
    chk("limit_hops_lit", {24'd0, HOPS}, 4);
`endif
    self_loop_start();
    repeat (4) @(posedge CLK);
    #1 chk("abort_hops_lit", {24'd0, HOPS}, 2);
    RST = 1;
    @(posedge CLK);
    #1 chk_reset("abort");
    free_run = 0;
    launch(32'h85, 1);
    for (int i = 0; i < 20 && !done_seen; i++) @(posedge CLK);
    if (!done_seen) chk("post_reset_timeout", 0, 1);
`ifndef FAT_CHAIN_HOP_LIMIT_EN
    self_loop_start();
    repeat (600) @(posedge CLK);
    #1 chk("sat_hops", {24'd0, HOPS}, 255);
    chk("sat_busy", {31'd0, BUSY}, 1);
    RST = 1;
    @(posedge CLK);
    #1 RST = 0;
    free_run = 0;
`endif
    run(32'h85, 0);
    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fat_sector_chain_reader.md
FAT_SECTOR_CHAIN_READER -- requirements
Module: fat_sector_chain_reader

Interface
REQ-001 Parameter HOP_LIMIT, 128, maximum entries evaluated per START when the limit feature is compiled in.
REQ-002 CLK  in  1  sole clock; all logic on posedge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 START  in  1  one-cycle request; sampled only in IDLE.
REQ-005 START_CLUST  in  32  cluster whose FAT entry is read first.
REQ-006 SECTOR_BASE  in  32  cluster index of entry 0 of the loaded FAT sector; bits [6:0] are ignored.
REQ-007 SECTOR_VALID  in  1  sector buffer holds a valid FAT sector.
REQ-008 RENA_SR  out  1  sector-buffer read enable.
REQ-009 RADDR_SR  out  8  sector-buffer word address (0..127).
REQ-010 INPUT_SR  in  32  buffer read data, valid the cycle after RENA_SR.
REQ-011 BUSY  out  1  high from the cycle after START is accepted until DONE.
REQ-012 DONE  out  1  one-cycle completion pulse.
REQ-013 STATUS  out  3  termination reason, valid while DONE is high and held until the next START.
REQ-014 LAST_CLUST  out  32  last cluster whose entry was read.
REQ-015 NEXT_CLUST  out  32  decoded 28-bit entry of LAST_CLUST, zero-extended.
REQ-016 HOPS  out  8  number of entries read for this request.

Function
REQ-017 States are IDLE, ISSUE, EVAL and DONE; DONE is a single cycle, after which the FSM returns to IDLE.
REQ-018 IDLE with START=1: cur<=START_CLUST and HOPS<=0; if SECTOR_VALID=0, or START_CLUST[31:7]!=SECTOR_BASE[31:7], or START_CLUST<2, go to DONE with STATUS=MISS (or RSVD when <2) and HOPS=0; otherwise go to ISSUE.
REQ-019 ISSUE: RENA_SR=1 and RADDR_SR={1'b0,cur[6:0]} for exactly one cycle; next state is EVAL.
REQ-020 EVAL samples INPUT_SR and decodes the entry by swapping the two nibbles of each byte (entry[31:28]=IN[27:24], entry[27:24]=IN[31:28], and the same for the other three bytes); it then masks bits [31:28] to zero and increments HOPS.
REQ-021 Decode classes, in priority order: 0 is FREE; 0x0FFFFFF8..0x0FFFFFFF is EOC; 0x0FFFFFF7 is BAD; 1, or any value >=0x0FFFFFF0 not already matched, is RSVD; anything else is a LINK.
REQ-022 EVAL on LINK: if the next cluster lies in the loaded sector, cur<=next and the FSM returns to ISSUE; otherwise it goes to DONE with STATUS=OUT.
REQ-023 EVAL on any non-LINK class goes to DONE with the matching STATUS.
REQ-024 LAST_CLUST and NEXT_CLUST update in every EVAL.
REQ-025 Latency: DONE asserts 3 cycles after the START cycle for 1 hop, plus 2 cycles per additional hop; DONE asserts 1 cycle after START for MISS or RSVD at START.
REQ-026 A self-loop (entry equal to cur) is followed like any LINK; only the limit feature terminates it.
REQ-027 START outside IDLE is ignored.
REQ-028 A change to SECTOR_BASE or SECTOR_VALID while BUSY is undefined input; the caller must not do it.
REQ-029 RENA_SR=0 in every state except ISSUE; RADDR_SR holds its last value.

Reset
REQ-030 RST=1 forces IDLE with BUSY, DONE, RENA_SR=0; RADDR_SR, HOPS, LAST_CLUST, NEXT_CLUST=0; and STATUS=OUT.
REQ-031 Reset mid-operation aborts with no DONE pulse; the first START accepted is the one sampled in the cycle after RST deasserts.

Configuration
REQ-032 FAT_CHAIN_HOP_LIMIT_EN defined: when HOPS reaches HOP_LIMIT in EVAL on a LINK that is still in the sector, the FSM goes to DONE with STATUS=LIMIT.
REQ-033 FAT_CHAIN_HOP_LIMIT_EN undefined: there is no limit, LIMIT is never reported, and HOPS saturates at 255.

Structure
REQ-034 STATUS codes are defined as constants in the shared defines include: OUT=0, EOC=1, FREE=2, BAD=3, RSVD=4, MISS=5, LIMIT=6.
REQ-035 The EOC and BAD threshold constants are defined in the same shared defines include.
REQ-036 Nibble un-swap and classification are implemented in one combinational sub-module, fat_entry_decode (input 32-bit raw word; outputs 28-bit value and class).

Verification
REQ-037 SECTOR_BASE=0x80, word 5 holds the swapped form of 0x0FFFFFFF; START_CLUST=0x85 -> RADDR_SR=5, STATUS=EOC, HOPS=1, DONE 3 cycles after START.
REQ-038 Chain 0x82->0x83->0x84->EOC inside sector 0x80 -> RADDR_SR sequence 2,3,4; HOPS=3; LAST_CLUST=0x84; DONE 7 cycles after START.
REQ-039 Entry of 0x90 = 0x105 with SECTOR_BASE=0x80 -> STATUS=OUT, NEXT_CLUST=0x105, HOPS=1.
REQ-040 START_CLUST=0x200 with SECTOR_BASE=0x80, and separately SECTOR_VALID=0 -> STATUS=MISS, HOPS=0, RENA_SR never asserted.
REQ-041 Entry of 0x81 = 0x81 with the limit feature in and HOP_LIMIT=4 -> STATUS=LIMIT, HOPS=4; the same case with RST pulsed after 2 hops -> no DONE, all outputs at their reset values.
REQ-042 Entry raw values 0x00000000 and the swapped form of 0x0FFFFFF7 -> STATUS=FREE and STATUS=BAD respectively; START pulsed while BUSY -> ignored.
